// File: rtl/stft_sweep_ctrl_if.sv
// Sample-side handshake plus Xk RAM / twiddle ROM / SPU signals of the STFT sweep controller.
// The master modport is the controller; the slave modport is the sample source and SPU side.
interface stft_sweep_ctrl_if #(
  parameter int WORD_WIDTH = 16,
  parameter int IDX_W      = 9
);
  logic                         s_valid;
  logic signed [WORD_WIDTH-1:0] s_sample;
  logic                         s_ready;
  logic                         xk_rd_en;
  logic [IDX_W-1:0]             xk_rd_addr;
  logic [IDX_W-1:0]             tw_addr;
  logic signed [WORD_WIDTH-1:0] spu_sample_diff;
  logic                         spu_wr_en;
  logic [IDX_W-1:0]             spu_idx;
  logic                         spu_o_wr_en;
  logic                         busy;
  logic                         sweep_done;
  logic                         diff_sat;

  modport master (
    input  s_valid, s_sample, spu_o_wr_en,
    output s_ready, xk_rd_en, xk_rd_addr, tw_addr, spu_sample_diff,
           spu_wr_en, spu_idx, busy, sweep_done, diff_sat
  );

  modport slave (
    output s_valid, s_sample, spu_o_wr_en,
    input  s_ready, xk_rd_en, xk_rd_addr, tw_addr, spu_sample_diff,
           spu_wr_en, spu_idx, busy, sweep_done, diff_sat
  );
endinterface

// File: rtl/stft_sweep_ctrl.sv
// Sliding-DFT sweep sequencer: one FFT_SIZE-bin SPU sweep per accepted sample.
// Optional STFT_SWEEP_STALL_EN adds a 'stall' input that freezes bin issue during SWEEP.
module stft_sweep_ctrl #(
  parameter int WORD_WIDTH  = 16,
  parameter int FFT_SIZE    = 512,
  parameter int RAM_LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
`ifdef STFT_SWEEP_STALL_EN
  input  logic stall,
`endif
  stft_sweep_ctrl_if.master bus
);
  localparam int IDX_W = $clog2(FFT_SIZE);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {CLEAR, IDLE, LOAD, SWEEP, DRAIN} state_t;

  state_t                        state, state_nx;
  logic [IDX_W-1:0]              ptr, bin;
  logic [CNT_W-1:0]              done_cnt;
  logic signed [WORD_WIDTH-1:0]  history [FFT_SIZE];
  logic signed [WORD_WIDTH-1:0]  sample_q, oldest_q;
  logic signed [WORD_WIDTH:0]    diff_wide;
  logic signed [WORD_WIDTH-1:0]  diff_clip;
  logic                          diff_ovf;
  logic                          hs, done, issue, stall_w;
  logic [RAM_LATENCY:1]              vld_pipe;
  logic [RAM_LATENCY:1][IDX_W-1:0]   idx_pipe;

`ifdef STFT_SWEEP_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign hs   = bus.s_valid & bus.s_ready;
  assign done = (state == DRAIN) && (done_cnt == CNT_W'(FFT_SIZE));

  // Difference at W+1 bits, clipped back to W bits on overflow.
  assign diff_wide = (WORD_WIDTH+1)'(sample_q) - (WORD_WIDTH+1)'(oldest_q);
  assign diff_ovf  = diff_wide[WORD_WIDTH] ^ diff_wide[WORD_WIDTH-1];
  assign diff_clip = !diff_ovf ? diff_wide[WORD_WIDTH-1:0] :
                     diff_wide[WORD_WIDTH] ? {1'b1, {(WORD_WIDTH-1){1'b0}}}
                                           : {1'b0, {(WORD_WIDTH-1){1'b1}}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= CLEAR;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (ptr == IDX_W'(FFT_SIZE-1)) state_nx = IDLE;
      IDLE:    if (hs) state_nx = LOAD;
      LOAD:    state_nx = SWEEP;
      SWEEP:   if (issue && bin == IDX_W'(FFT_SIZE-1)) state_nx = DRAIN;
      DRAIN:   if (done) state_nx = hs ? LOAD : IDLE;
      default: state_nx = CLEAR;
    endcase
  end

  // The DRAIN exit cycle already offers s_ready so the next sample is not delayed.
  always_comb begin
    bus.s_ready    = 1'b0;
    bus.busy       = 1'b1;
    bus.sweep_done = 1'b0;
    issue          = 1'b0;
    case (state)
      IDLE: begin
        bus.s_ready = 1'b1;
        bus.busy    = 1'b0;
      end
      SWEEP: issue = !stall_w;
      DRAIN: if (done) begin
        bus.sweep_done = 1'b1;
        bus.s_ready    = 1'b1;
        bus.busy       = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.xk_rd_en   = issue;
  assign bus.xk_rd_addr = bin;
  assign bus.tw_addr    = bin;
  assign bus.spu_wr_en  = vld_pipe[RAM_LATENCY];
  assign bus.spu_idx    = idx_pipe[RAM_LATENCY];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr                 <= '0;
      bin                 <= '0;
      done_cnt            <= '0;
      sample_q            <= '0;
      oldest_q            <= '0;
      bus.spu_sample_diff <= '0;
      bus.diff_sat        <= 1'b0;
      vld_pipe            <= '0;
      idx_pipe            <= '0;
    end else begin
      if (state == CLEAR || state == LOAD) ptr <= ptr + 1'b1;
      if (hs) begin
        sample_q <= bus.s_sample;
        oldest_q <= history[ptr];
      end
      if (state == LOAD) begin
        bus.spu_sample_diff <= diff_clip;
        bus.diff_sat        <= bus.diff_sat | diff_ovf;
        bin                 <= '0;
      end else if (issue) begin
        bin <= bin + 1'b1;
      end
      if (done)
        done_cnt <= '0;
      else if (bus.spu_o_wr_en && (state == SWEEP || state == DRAIN))
        done_cnt <= done_cnt + 1'b1;
      vld_pipe[1] <= issue;
      idx_pipe[1] <= bin;
      for (int i = 2; i <= RAM_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  // History RAM has no reset; CLEAR zeroes it entry by entry.
  always_ff @(posedge clk) begin
    if (state == CLEAR)     history[ptr] <= '0;
    else if (state == LOAD) history[ptr] <= sample_q;
  end
endmodule

// File: tb/tb_stft_sweep_ctrl.sv
// Bench for stft_sweep_ctrl (FFT_SIZE=8, RAM_LATENCY=1) with a 3-cycle SPU model and scoreboard.
module tb_stft_sweep_ctrl;
  localparam int N = 8;
  localparam int W = 16;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic stall = 1'b0;
  logic [2:0] spu_pipe = '0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int stall_extra = 0;
  int exp_diff[$];
  int exp_start[$];
  int exp_done[$];
  int exp_addr = 0;
  int exp_idx = 0;

  stft_sweep_ctrl_if #(.WORD_WIDTH(W), .IDX_W(IW)) bus ();

  stft_sweep_ctrl #(.WORD_WIDTH(W), .FFT_SIZE(N), .RAM_LATENCY(1)) dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef STFT_SWEEP_STALL_EN
    .stall(stall),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SPU model: o_wr_en three cycles after wr_en
  always @(posedge clk) spu_pipe <= {spu_pipe[1:0], bus.spu_wr_en};
  assign bus.spu_o_wr_en = spu_pipe[2];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not expected/not seen (cycle %0d)", name, cyc);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_addr = 0;
      exp_idx  = 0;
      exp_diff.delete();
      exp_start.delete();
      exp_done.delete();
    end else begin
      if (bus.xk_rd_en) begin
        if (exp_addr == 0) begin
          if (exp_start.size() == 0) flag_fail("unexpected_sweep_start");
          else chk("first_addr_cycle", cyc, exp_start.pop_front());
        end
        chk("xk_rd_addr", bus.xk_rd_addr, exp_addr);
        chk("tw_addr", bus.tw_addr, exp_addr);
        exp_addr = (exp_addr + 1) % N;
      end
      if (bus.spu_wr_en) begin
        chk("spu_idx", bus.spu_idx, exp_idx);
        if (exp_idx == 0) begin
          if (exp_diff.size() == 0) flag_fail("unexpected_diff");
          else chk("spu_sample_diff", bus.spu_sample_diff, exp_diff.pop_front());
        end
        exp_idx = (exp_idx + 1) % N;
      end
      if (bus.sweep_done) begin
        if (exp_done.size() == 0) flag_fail("unexpected_sweep_done");
        else chk("sweep_done_cycle", cyc, exp_done.pop_front());
        chk("done_s_ready", bus.s_ready, 1);
        chk("done_busy", bus.busy, 0);
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    bus.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_xk_rd_en", bus.xk_rd_en, 0);
    chk("rst_spu_wr_en", bus.spu_wr_en, 0);
    chk("rst_sweep_done", bus.sweep_done, 0);
    chk("rst_diff_sat", bus.diff_sat, 0);
    chk("rst_diff", bus.spu_sample_diff, 0);
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk("clear_s_ready", bus.s_ready, 0);
      chk("clear_busy", bus.busy, 1);
      @(negedge clk);
    end
    chk("idle_s_ready", bus.s_ready, 1);
    chk("idle_busy", bus.busy, 0);
  endtask

  task automatic send(input int smp, input int exp);
    int n = 0;
    bus.s_valid  = 1'b1;
    bus.s_sample = W'(smp);
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) begin
      flag_fail("handshake_timeout");
    end else begin
      exp_diff.push_back(exp);
      exp_start.push_back(cyc + 2);
      exp_done.push_back(cyc + 14 + stall_extra);
      @(negedge clk);
      chk("s_ready_after_hs", bus.s_ready, 0);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_done.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_done.size() != 0) flag_fail("sweep_done_timeout");
    chk("diff_queue_left", exp_diff.size(), 0);
  endtask

  task automatic wait_addr(input int a);
    int n = 0;
    while (!(bus.xk_rd_en && bus.xk_rd_addr == IW'(a)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) flag_fail("addr_wait_timeout");
  endtask

  initial begin
    bus.s_valid  = 1'b0;
    bus.s_sample = '0;
    @(negedge clk);
    do_reset();

    send(100, 100);
    wait_done();
    chk("diff_sat_single", bus.diff_sat, 0);

    // history wrap: ninth sample sees the first one
    do_reset();
    for (int k = 1; k <= 9; k++) send(10 * k, (k == 9) ? 80 : 10 * k);
    wait_done();

    // saturation in both directions
    do_reset();
    send(-32768, -32768);
    send(32767, 32767);
    for (int k = 0; k < 6; k++) send(0, 0);
    wait_done();
    chk("diff_sat_before", bus.diff_sat, 0);
    send(32767, 32767);
    wait_done();
    chk("diff_sat_pos", bus.diff_sat, 1);
    send(-32768, -32768);
    send(0, 0);
    wait_done();
    chk("diff_sat_sticky", bus.diff_sat, 1);

    // reset mid-SWEEP
    send(7, 7);
    wait_addr(3);
    reset_n = 1'b0;
    #1;
    chk("midrst_s_ready", bus.s_ready, 0);
    chk("midrst_xk_rd_en", bus.xk_rd_en, 0);
    chk("midrst_spu_wr_en", bus.spu_wr_en, 0);
    chk("midrst_sweep_done", bus.sweep_done, 0);
    chk("midrst_diff", bus.spu_sample_diff, 0);
    chk("midrst_diff_sat", bus.diff_sat, 0);
    @(negedge clk);
    do_reset();
    send(5, 5);
    wait_done();

`ifdef STFT_SWEEP_STALL_EN
    stall_extra = 3;
    send(9, 9);
    wait_addr(3);
    @(posedge clk);
    #1 stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    wait_done();
    stall_extra = 0;
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
